pool_engine: RTL and testbench
==============================

POOL_ENGINE -- requirements
Module: pool_engine

Parameters
REQ-001 The block SHALL have parameter DW, default 32, meaning the signed sample width.
REQ-002 The block SHALL have parameter AW, default 14, meaning the address width.
REQ-003 The block SHALL have parameter CH, default 10, meaning the channel (batch) count.
REQ-004 The block SHALL have parameters IN_H and IN_W, default 10 each, meaning the input plane height and width.
REQ-005 The block SHALL have parameter K, default 2, meaning the KxK window size; legal values are 1, 2 and 4.
REQ-006 The block SHALL have parameter STRIDE, default 2, meaning the window step in both axes.
REQ-007 The block SHALL have parameter RD_LAT, default 1 (range 1..4), meaning the memory read latency in cycles.
REQ-008 The block SHALL derive OUT_H = (IN_H-K)/STRIDE+1 and OUT_W = (IN_W-K)/STRIDE+1.

Interface
REQ-009 Clk, input, 1: the clock.
REQ-010 Reset, input, 1: synchronous, active-high reset.
REQ-011 start, input, 1: one-cycle request to begin a pass; sampled only in IDLE.
REQ-012 mode, input, 1: 0 = max pooling, 1 = average pooling; latched when start is accepted.
REQ-013 in_base, out_base, input, AW each: base addresses; latched when start is accepted.
REQ-014 rd_addr, output, AW, and rd_en, output, 1: read request; rd_data, input, DW signed, is valid RD_LAT cycles after an rd_en cycle.
REQ-015 wr_addr, output, AW; wr_data, output, DW signed; wr_en, output, 1: result write port.
REQ-016 busy, output, 1: high from the cycle after start is accepted until DONE.
REQ-017 done, output, 1: one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, READ, DRAIN, WRITE and DONE.
REQ-019 IDLE->READ SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-020 READ SHALL last exactly K*K cycles with rd_en=1 throughout.
REQ-021 In READ, rd_addr SHALL equal in_base + c*IN_H*IN_W + (oy*STRIDE+ky)*IN_W + ox*STRIDE + kx.
REQ-022 In READ, kx SHALL increment fastest and then ky.
REQ-023 DRAIN SHALL last RD_LAT cycles with rd_en=0, then pass to WRITE.
REQ-024 The returned samples SHALL be tracked by a RD_LAT-deep valid shift register, and the accumulator SHALL update only on a valid sample.
REQ-025 In max mode, the first sample of a window SHALL initialise the accumulator, and later samples SHALL replace it when greater (signed).
REQ-026 In average mode, the sum SHALL be held at DW+4 bits signed without overflow.
REQ-027 In average mode, the result SHALL be sum >>> log2(K*K), an arithmetic shift that rounds toward -infinity, truncated to DW.
REQ-028 WRITE SHALL last one cycle with wr_en=1 and wr_addr = out_base + c*OUT_H*OUT_W + oy*OUT_W + ox.
REQ-029 After WRITE, ox SHALL advance first, then oy, then c, each wrapping to 0 at its limit.
REQ-030 After the write for c=CH-1, oy=OUT_H-1, ox=OUT_W-1, the next state SHALL be DONE; otherwise it SHALL be READ.
REQ-031 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-032 A start asserted during the DONE cycle SHALL be ignored.
REQ-033 Cycles per window SHALL be K*K+RD_LAT+1; a full pass SHALL take CH*OUT_H*OUT_W*(K*K+RD_LAT+1)+1 cycles from start acceptance to done. With defaults: 250 windows, 1501 cycles.
REQ-034 Windows SHALL never read outside the input plane; input rows and columns beyond the last full window SHALL be ignored.
REQ-035 In IDLE and DONE, rd_en and wr_en SHALL be 0.

Reset
REQ-036 Reset SHALL force state IDLE; all counters, the accumulator and the valid pipeline to 0; and rd_en, wr_en, busy and done to 0.
REQ-037 Reset asserted mid-pass SHALL abort the pass with no further writes and no done pulse.
REQ-038 After such an abort, the next start SHALL begin a fresh pass at c=oy=ox=0.

Verification
REQ-039 The bench SHALL cover: defaults, mode=0, input[i]=i for i in 0..999, in_base=0, out_base=1000 -> window (c0,0,0) reads 0,1,10,11 and writes 11 at address 1000; last write is 999 at address 1249; done after 1501 cycles.
REQ-040 The bench SHALL cover: defaults, mode=1, window samples 3,4,5,7 -> wr_data=4; samples -1,-2,-2,-2 -> wr_data=-2 (floor).
REQ-041 The bench SHALL cover: max mode with samples 0x80000000,-5,-7,-9 -> wr_data=-5 (signed compare, not unsigned).
REQ-042 The bench SHALL cover: RD_LAT=3, K=2 -> 8 cycles per window, and wr_data matches a reference model for all 250 outputs.
REQ-043 The bench SHALL cover: Reset asserted at cycle 700 of a pass -> wr_en=0 from the next cycle, no done, and a following start gives first rd_addr=in_base.
REQ-044 The bench SHALL cover: start held high continuously during a pass -> exactly one pass, one done pulse, no restart before IDLE.

Source files
------------

// File: rtl/pool_engine.sv
// pool_engine: KxK max/average pooling of a CH-channel plane held in external memory
module pool_engine #(
  parameter int DW     = 32,
  parameter int AW     = 14,
  parameter int CH     = 10,
  parameter int IN_H   = 10,
  parameter int IN_W   = 10,
  parameter int K      = 2,
  parameter int STRIDE = 2,
  parameter int RD_LAT = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [AW-1:0]        in_base,
  input  logic [AW-1:0]        out_base,
  output logic [AW-1:0]        rd_addr,
  output logic                 rd_en,
  input  logic signed [DW-1:0] rd_data,
  output logic [AW-1:0]        wr_addr,
  output logic signed [DW-1:0] wr_data,
  output logic                 wr_en,
  output logic                 busy,
  output logic                 done
);
  localparam int OUT_H = (IN_H - K) / STRIDE + 1;
  localparam int OUT_W = (IN_W - K) / STRIDE + 1;
  localparam int KK    = K * K;
  localparam int SH    = $clog2(KK);
  localparam int ACC_W = DW + 4;
  localparam int KW    = $clog2(K) + 1;
  localparam int SW    = $clog2(KK) + 1;
  localparam int LW    = $clog2(RD_LAT) + 1;
  localparam int CW    = $clog2(CH) + 1;
  localparam int YW    = $clog2(OUT_H) + 1;
  localparam int XW    = $clog2(OUT_W) + 1;
  localparam logic [KW-1:0] K_MAX = KW'(K - 1);
  localparam logic [SW-1:0] S_MAX = SW'(KK - 1);
  localparam logic [LW-1:0] L_MAX = LW'(RD_LAT - 1);
  localparam logic [CW-1:0] C_MAX = CW'(CH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(OUT_H - 1);
  localparam logic [XW-1:0] X_MAX = XW'(OUT_W - 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t                  state, state_nx;
  logic [KW-1:0]           kx, ky;
  logic [LW-1:0]           lat;
  logic [SW-1:0]           smp;
  logic [CW-1:0]           c;
  logic [YW-1:0]           oy;
  logic [XW-1:0]           ox;
  logic [RD_LAT-1:0]       vld;
  logic signed [ACC_W-1:0] acc, smp_x;
  logic                    mode_q;
  logic [AW-1:0]           in_q, out_q;
  logic                    k_last, x_last, y_last, c_last, last, valid;

  assign k_last  = kx == K_MAX && ky == K_MAX;
  assign x_last  = ox == X_MAX;
  assign y_last  = oy == Y_MAX;
  assign c_last  = c == C_MAX;
  assign last    = x_last && y_last && c_last;
  assign valid   = vld[RD_LAT-1];
  assign smp_x   = {{4{rd_data[DW-1]}}, rd_data};
  assign rd_addr = in_q + AW'(32'(c) * (IN_H * IN_W) + (32'(oy) * STRIDE + 32'(ky)) * IN_W
                              + 32'(ox) * STRIDE + 32'(kx));
  assign wr_addr = out_q + AW'(32'(c) * (OUT_H * OUT_W) + 32'(oy) * OUT_W + 32'(ox));
  assign wr_data = mode_q ? DW'(acc >>> SH) : DW'(acc);

  // state register
  always_ff @(posedge Clk) state <= Reset ? IDLE : state_nx;

  // next-state: read the window, wait out the memory latency, write, repeat
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? READ : IDLE;
      READ:    state_nx = k_last ? DRAIN : READ;
      DRAIN:   state_nx = lat == L_MAX ? WRITE : DRAIN;
      WRITE:   state_nx = last ? DONE : READ;
      default: state_nx = IDLE;
    endcase
  end

  // outputs decoded from the current state
  always_comb begin
    rd_en = state == READ;
    wr_en = state == WRITE;
    busy  = state == READ || state == DRAIN || state == WRITE;
    done  = state == DONE;
  end

  // window offsets, output position and configuration latched at start
  always_ff @(posedge Clk)
    if (Reset) begin
      kx     <= '0;
      ky     <= '0;
      lat    <= '0;
      c      <= '0;
      oy     <= '0;
      ox     <= '0;
      mode_q <= 1'b0;
      in_q   <= '0;
      out_q  <= '0;
    end else begin
      if (state == IDLE && start) begin
        mode_q <= mode;
        in_q   <= in_base;
        out_q  <= out_base;
      end
      if (state == READ) begin
        kx <= kx == K_MAX ? '0 : kx + 1'b1;
        ky <= kx == K_MAX ? (ky == K_MAX ? '0 : ky + 1'b1) : ky;
      end
      lat <= state == DRAIN && lat != L_MAX ? lat + 1'b1 : '0;
      if (state == WRITE) begin
        ox <= x_last ? '0 : ox + 1'b1;
        oy <= x_last ? (y_last ? '0 : oy + 1'b1) : oy;
        c  <= x_last && y_last ? (c_last ? '0 : c + 1'b1) : c;
      end
    end

  // track returning samples and fold them into the running max or sum
  always_ff @(posedge Clk)
    if (Reset) begin
      vld <= '0;
      smp <= '0;
      acc <= '0;
    end else begin
      vld <= RD_LAT'({vld, rd_en});
      if (valid) begin
        smp <= smp == S_MAX ? '0 : smp + 1'b1;
        acc <= smp == '0 ? smp_x : mode_q ? acc + smp_x : (smp_x > acc ? smp_x : acc);
      end
    end
endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: directed passes of pool_engine checked against a window-level reference model
module tb_pool_engine;
  localparam int DW = 32;
  localparam int AW = 14;

  logic                 Clk = 1'b0;
  logic                 Reset = 1'b1;
  logic                 start_a = 1'b0, start_b = 1'b0, mode = 1'b0;
  logic [AW-1:0]        in_base = '0, out_base = '0;
  logic [AW-1:0]        rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic                 rd_en_a, rd_en_b, wr_en_a, wr_en_b, busy_a, busy_b, done_a, done_b;
  logic signed [DW-1:0] rd_data_a, rd_data_b, wr_data_a, wr_data_b;
  logic signed [DW-1:0] mem [0:2047];
  logic signed [DW-1:0] outm [0:2047];
  logic signed [DW-1:0] pa, pb0, pb1, pb2;

  bit                   act = 1'b0, chk = 1'b0;
  int                   n_pass = 0, n_tot = 0;
  int                   cyc = 0, last_wr = 0, nwr = 0, nrd = 0, ndone = 0, per_win = 6;
  int                   extra_rd = 0, extra_wr = 0, last_wa = 0;
  int                   rd_first [4];
  int                   exp_rd [$];
  int                   exp_wa [$];
  longint               exp_wd [$];

  logic [AW-1:0]        rd_addr_x, wr_addr_x;
  logic                 rd_en_x, wr_en_x, busy_x, done_x;
  logic signed [DW-1:0] wr_data_x;

  always #5 Clk = ~Clk;

  pool_engine dut_a (
    .Clk(Clk), .Reset(Reset), .start(start_a), .mode(mode), .in_base(in_base), .out_base(out_base),
    .rd_addr(rd_addr_a), .rd_en(rd_en_a), .rd_data(rd_data_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .wr_en(wr_en_a), .busy(busy_a), .done(done_a)
  );

  pool_engine #(.RD_LAT(3)) dut_b (
    .Clk(Clk), .Reset(Reset), .start(start_b), .mode(mode), .in_base(in_base), .out_base(out_base),
    .rd_addr(rd_addr_b), .rd_en(rd_en_b), .rd_data(rd_data_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .wr_en(wr_en_b), .busy(busy_b), .done(done_b)
  );

  // memory with 1- and 3-cycle read latency; junk is returned when no read was issued
  always @(posedge Clk) begin
    pa  <= rd_en_a ? mem[rd_addr_a[10:0]] : 32'sh5A5A_5A5A;
    pb0 <= rd_en_b ? mem[rd_addr_b[10:0]] : 32'sh5A5A_5A5A;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign rd_data_a = pa;
  assign rd_data_b = pb2;

  assign rd_addr_x = act ? rd_addr_b : rd_addr_a;
  assign wr_addr_x = act ? wr_addr_b : wr_addr_a;
  assign wr_data_x = act ? wr_data_b : wr_data_a;
  assign rd_en_x   = act ? rd_en_b : rd_en_a;
  assign wr_en_x   = act ? wr_en_b : wr_en_a;
  assign busy_x    = act ? busy_b : busy_a;
  assign done_x    = act ? done_b : done_a;

  task automatic check(input string name, input longint got, input longint want);
    n_tot++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic longint fdiv(input longint s, input longint d);
    return (s < 0 && s % d != 0) ? s / d - 1 : s / d;
  endfunction

  // every window of every channel: expected read addresses, write address and result
  task automatic build_model(input logic m, input int ib, input int ob);
    longint s, mx, v;
    int     a;
    exp_rd.delete();
    exp_wa.delete();
    exp_wd.delete();
    for (int c = 0; c < 10; c++)
      for (int oy = 0; oy < 5; oy++)
        for (int ox = 0; ox < 5; ox++) begin
          s  = 0;
          mx = 0;
          for (int ky = 0; ky < 2; ky++)
            for (int kx = 0; kx < 2; kx++) begin
              a = ib + c * 100 + (oy * 2 + ky) * 10 + ox * 2 + kx;
              exp_rd.push_back(a);
              v = mem[a];
              s += v;
              if ((ky == 0 && kx == 0) || v > mx) mx = v;
            end
          exp_wa.push_back(ob + c * 25 + oy * 5 + ox);
          exp_wd.push_back(m ? fdiv(s, 4) : mx);
        end
  endtask

  // compare process: DUT outputs against the model on every cycle they matter
  initial forever begin
    @(negedge Clk);
    cyc++;
    if (chk) begin
      if (rd_en_x) begin
        if (nrd < 4) rd_first[nrd] = int'(rd_addr_x);
        nrd++;
        if (exp_rd.size() == 0) extra_rd++;
        else check("rd_addr", rd_addr_x, exp_rd.pop_front());
      end
      if (wr_en_x) begin
        if (nwr > 0) check("win_cycles", cyc - last_wr, per_win);
        last_wr = cyc;
        nwr++;
        last_wa = int'(wr_addr_x);
        outm[wr_addr_x[10:0]] = wr_data_x;
        if (exp_wa.size() == 0) extra_wr++;
        else begin
          check("wr_addr", wr_addr_x, exp_wa.pop_front());
          check("wr_data", wr_data_x, exp_wd.pop_front());
        end
      end
      if (done_x) ndone++;
    end
  end

  task automatic run_pass(input bit sel, input logic m, input int ib, input int ob, input bit hold,
                          input int cycles);
    int n;
    chk      = 1'b0;
    act      = sel;
    mode     = m;
    in_base  = AW'(ib);
    out_base = AW'(ob);
    per_win  = sel ? 8 : 6;
    build_model(m, ib, ob);
    nrd      = 0;
    nwr      = 0;
    ndone    = 0;
    extra_rd = 0;
    extra_wr = 0;
    @(negedge Clk);
    chk = 1'b1;
    if (sel) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge Clk);
    #1;
    if (!hold) begin
      start_a = 1'b0;
      start_b = 1'b0;
    end
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (n == 1) check("busy_first", busy_x, 1);
    end while (!done_x && n < 4000);
    check("pass_cycles", n, cycles);
    check("busy_at_done", busy_x, 0);
    if (hold) begin
      @(posedge Clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
    end
    repeat (3) begin
      @(negedge Clk);
      check("idle_busy", busy_x, 0);
      check("idle_rd_en", rd_en_x, 0);
    end
    check("rd_extra", extra_rd, 0);
    check("wr_extra", extra_wr, 0);
    check("rd_missing", exp_rd.size(), 0);
    check("wr_missing", exp_wa.size(), 0);
    check("done_pulses", ndone, 1);
  endtask

  initial begin
    int wr_seen, done_seen, busy_seen;
    for (int i = 0; i < 2048; i++) mem[i] = i;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rd_en", rd_en_a, 0);
    check("rst_wr_en", wr_en_a, 0);
    check("rst_busy_b", busy_b, 0);
    Reset = 1'b0;

    run_pass(1'b0, 1'b0, 0, 1000, 1'b0, 1501);
    check("rd0", rd_first[0], 0);
    check("rd1", rd_first[1], 1);
    check("rd2", rd_first[2], 10);
    check("rd3", rd_first[3], 11);
    check("max_first", outm[1000], 11);
    check("last_addr", last_wa, 1249);
    check("last_data", outm[1249], 999);

    for (int i = 0; i < 1000; i++) mem[i] = DW'($urandom);
    mem[0]  = 3;
    mem[1]  = 4;
    mem[10] = 5;
    mem[11] = 7;
    mem[2]  = -1;
    mem[3]  = -2;
    mem[12] = -2;
    mem[13] = -2;
    run_pass(1'b0, 1'b1, 0, 1000, 1'b0, 1501);
    check("avg_pos", outm[1000], 4);
    check("avg_floor", outm[1001], -2);

    mem[0]  = 32'h8000_0000;
    mem[1]  = -5;
    mem[10] = -7;
    mem[11] = -9;
    run_pass(1'b0, 1'b0, 0, 1000, 1'b1, 1501);
    check("max_signed", outm[1000], -5);

    run_pass(1'b1, 1'b1, 0, 1200, 1'b0, 2001);
    run_pass(1'b1, 1'b0, 0, 1200, 1'b0, 2001);

    chk      = 1'b0;
    act      = 1'b0;
    mode     = 1'b0;
    in_base  = '0;
    out_base = AW'(1000);
    @(negedge Clk);
    start_a = 1'b1;
    @(posedge Clk);
    #1;
    start_a = 1'b0;
    repeat (699) @(posedge Clk);
    #1;
    check("abort_busy_before", busy_a, 1);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset     = 1'b0;
    wr_seen   = 0;
    done_seen = 0;
    busy_seen = 0;
    repeat (20) begin
      @(negedge Clk);
      if (wr_en_a) wr_seen++;
      if (done_a) done_seen++;
      if (busy_a) busy_seen++;
    end
    check("abort_wr", wr_seen, 0);
    check("abort_done", done_seen, 0);
    check("abort_busy", busy_seen, 0);
    run_pass(1'b0, 1'b0, 5, 1000, 1'b0, 1501);
    check("restart_rd0", rd_first[0], 5);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
